// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control encodings and fetch FSM states
package pipe_pkg;

  localparam logic [1:0] CTR_ADV   = 2'b00;
  localparam logic [1:0] CTR_FLUSH = 2'b01;
  localparam logic [1:0] CTR_STALL = 2'b10;

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_JMPR = 2'b01;
  localparam logic [1:0] JT_JMPI = 2'b10;
  localparam logic [1:0] JT_INT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buf.sv
// rtl/fetch_unit_buf.sv - 2-entry {pc,inst} FIFO between imem and IF/ID
module fetch_buf #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_pc,
  input  logic [DW-1:0] push_inst,
  input  logic          pop,
  input  logic          flush,
  output logic [1:0]    count,
  output logic [AW-1:0] head_pc,
  output logic [DW-1:0] head_inst
);

  logic [AW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DW-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [1:0]    count_q, count_d;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      // Entry 0 is always the head; a pop shifts entry 1 down.
      if (pop_ok) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (push_ok) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)) begin
          pc0_d   = push_pc;
          inst0_d = push_inst;
        end else begin
          pc1_d   = push_pc;
          inst1_d = push_inst;
        end
      end
      if (push_ok && !pop_ok)      count_d = count_q + 2'd1;
      else if (pop_ok && !push_ok) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      inst0_q <= '0;
      inst1_q <= '0;
      count_q <= 2'd0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign head_pc   = (count_q != 2'd0) ? pc0_q : '0;
  assign head_inst = (count_q != 2'd0) ? inst0_q : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding imem handshake, redirect and epc capture
module fetch_unit
  import pipe_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] INT_VEC  = 'h80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ifid_ctr,
  input  logic [1:0]    jmp_type,
  input  logic [AW-1:0] jmpr_tgt,
  input  logic [AW-1:0] jmpi_tgt,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  output logic          if_valid,
  output logic [DW-1:0] if_inst,
  output logic [AW-1:0] if_pc,
  output logic [AW-1:0] epc,
  output logic          epc_we
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] epc_q, epc_d;
  logic          epc_we_q, epc_we_d;
  logic          redirect, push, pop, flush;
  logic [1:0]    count;

  assign redirect = (jmp_type != JT_NONE);
  assign pop      = (ifid_ctr == CTR_ADV) && (count != 2'd0);
  assign flush    = (ifid_ctr == CTR_FLUSH) || redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count != 2'd2) && !redirect) begin
          state_d = ST_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + AW'(4);
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // The abandoned request must still complete before a new one can issue.
        if (imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      case (jmp_type)
        JT_JMPR: fetch_pc_d = jmpr_tgt;
        JT_JMPI: fetch_pc_d = jmpi_tgt;
        default: fetch_pc_d = INT_VEC;
      endcase
    end

    epc_we_d = (jmp_type == JT_INT);
    epc_d    = epc_q;
    if (epc_we_d) epc_d = (count != 2'd0) ? if_pc : fetch_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      epc_q      <= '0;
      epc_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      epc_q      <= epc_d;
      epc_we_q   <= epc_we_d;
    end
  end

  fetch_buf #(.AW(AW), .DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (fetch_pc_q),
    .push_inst (imem_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_pc   (if_pc),
    .head_inst (if_inst)
  );

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = addr_q;
  assign if_valid  = (count != 2'd0);
  assign epc       = epc_q;
  assign epc_we    = epc_we_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [31:0] fw(input logic [31:0] a);
    fw = {a[15:0], ~a[15:0]};
  endfunction

  // Main instance, RESET_PC = 0
  logic        rst = 1'b0;
  logic [1:0]  ifid_ctr = CTR_STALL;
  logic [1:0]  jmp_type = JT_NONE;
  logic [31:0] jmpr_tgt = '0, jmpi_tgt = '0;
  logic        imem_req, imem_ack, if_valid, epc_we;
  logic [31:0] imem_addr, imem_data, if_inst, if_pc, epc;
  int          lat = 0;
  int          wcnt = 0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr = '0;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign imem_ack  = imem_req && (wcnt >= lat);
  assign imem_data = ovr_en ? ovr : fw(imem_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .ifid_ctr(ifid_ctr), .jmp_type(jmp_type),
    .jmpr_tgt(jmpr_tgt), .jmpi_tgt(jmpi_tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .epc(epc), .epc_we(epc_we)
  );

  // Wrap instance, RESET_PC = 0xFFFFFFFC, always advancing
  logic        rst2 = 1'b0;
  logic [1:0]  ifid2 = CTR_ADV;
  logic [1:0]  jmp2 = JT_NONE;
  logic [31:0] tgt2 = '0;
  logic        ack2_en = 1'b1;
  logic        req2, ack2, valid2, epc_we2;
  logic [31:0] addr2, data2, inst2, pc2, epc2;

  assign ack2  = req2 && ack2_en;
  assign data2 = fw(addr2);

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .ifid_ctr(ifid2), .jmp_type(jmp2),
    .jmpr_tgt(tgt2), .jmpi_tgt(tgt2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_data(data2),
    .if_valid(valid2), .if_inst(inst2), .if_pc(pc2), .epc(epc2), .epc_we(epc_we2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = fw(pc);
    return e;
  endfunction

  // One clock: pops are scored at the negedge preceding the popping posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (if_valid && ifid_ctr == CTR_ADV) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL pop_unexpected: pc=%h, no entry expected", if_pc);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          tests_failed++;
          $display("FAIL pop_order: got pc=%h inst=%h, want pc=%h inst=%h", if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b = 0;
    ifid_ctr = CTR_ADV;
    while (sb.size() != 0 && b < 100) begin
      cycle();
      b++;
    end
    ifid_ctr = CTR_STALL;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_req();
    int b = 0;
    while (!imem_req && b < 50) begin
      cycle();
      b++;
    end
    tests_run++;
    if (!imem_req) begin
      tests_failed++;
      $display("FAIL req_timeout: imem_req=%b, want 1", imem_req);
    end
  endtask

  task automatic restart(input logic [31:0] tgt);
    int b = 0;
    ifid_ctr = CTR_STALL;
    jmp_type = JT_JMPI;
    jmpi_tgt = tgt;
    cycle();
    jmp_type = JT_NONE;
    sb.delete();
    while (imem_req && b < 50) begin
      cycle();
      b++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || epc !== 32'h0 || epc_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: req=%b addr=%h epc=%h epc_we=%b, want 0", imem_req, imem_addr, epc, epc_we);
    end
    tests_run++;
    if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_head: valid=%b inst=%h pc=%h, want 0", if_valid, if_inst, if_pc);
    end
    tests_run++;
    if (req2 !== 1'b0 || addr2 !== 32'h0 || valid2 !== 1'b0 || epc2 !== 32'h0 || epc_we2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dut2: req=%b addr=%h valid=%b epc=%h we=%b, want 0", req2, addr2, valid2, epc2, epc_we2);
    end
  endtask

  task automatic test_fetch();
    int b = 0;
    lat = 0;
    sb.push_back(mk(32'h0));
    sb.push_back(mk(32'h4));
    sb.push_back(mk(32'h8));
    ifid_ctr = CTR_ADV;
    rst = 1'b1;
    wait_req();
    tests_run++;
    if (imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_addr: addr=%h, want 00000000", imem_addr);
    end
    while (!if_valid && b < 20) begin
      cycle();
      b++;
    end
    tests_run++;
    if (if_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_valid: if_valid=%b, want 1", if_valid);
    end
    drain();
  endtask

  task automatic test_stall();
    lat = 0;
    restart(32'h0);
    repeat (12) cycle();
    tests_run++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_full: req=%b valid=%b, want req=0 valid=1", imem_req, if_valid);
    end
    tests_run++;
    if (if_pc !== 32'h0 || if_inst !== fw(32'h0)) begin
      tests_failed++;
      $display("FAIL stall_head: pc=%h inst=%h, want pc=00000000 inst=%h", if_pc, if_inst, fw(32'h0));
    end
    sb.push_back(mk(32'h0));
    sb.push_back(mk(32'h4));
    drain();
  endtask

  task automatic test_drop();
    int b = 0;
    lat = 3;
    restart(32'h200);
    wait_req();
    tests_run++;
    if (imem_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL drop_issue: addr=%h, want 00000200", imem_addr);
    end
    jmp_type = JT_JMPI;
    jmpi_tgt = 32'h100;
    cycle();
    jmp_type = JT_NONE;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL drop_hold: req=%b addr=%h, want req=1 addr=00000200", imem_req, imem_addr);
    end
    while (imem_req && b < 20) begin
      cycle();
      b++;
    end
    tests_run++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_discard: req=%b valid=%b, want 0 0", imem_req, if_valid);
    end
    wait_req();
    tests_run++;
    if (imem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL drop_next: addr=%h, want 00000100", imem_addr);
    end
    sb.push_back(mk(32'h100));
    drain();
  endtask

  task automatic test_jmpr_on_ack();
    int b = 0;
    lat = 2;
    restart(32'h300);
    wait_req();
    while (!imem_ack && b < 20) begin
      cycle();
      b++;
    end
    ovr_en   = 1'b1;
    ovr      = 32'h0000_DEAD;
    jmp_type = JT_JMPR;
    jmpr_tgt = 32'h400;
    cycle();
    jmp_type = JT_NONE;
    ovr_en   = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL jmpr_discard: valid=%b req=%b, want 0 0", if_valid, imem_req);
    end
    wait_req();
    tests_run++;
    if (imem_addr !== 32'h400) begin
      tests_failed++;
      $display("FAIL jmpr_next: addr=%h, want 00000400", imem_addr);
    end
    sb.push_back(mk(32'h400));
    drain();
  endtask

  task automatic test_interrupt();
    int b = 0;
    lat = 0;
    restart(32'h8);
    while (!if_valid && b < 20) begin
      cycle();
      b++;
    end
    tests_run++;
    if (if_pc !== 32'h8) begin
      tests_failed++;
      $display("FAIL int_head: pc=%h, want 00000008", if_pc);
    end
    jmp_type = JT_INT;
    cycle();
    jmp_type = JT_NONE;
    tests_run++;
    if (epc !== 32'h8 || epc_we !== 1'b1 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL int_capture: epc=%h we=%b valid=%b, want 00000008 1 0", epc, epc_we, if_valid);
    end
    cycle();
    tests_run++;
    if (epc_we !== 1'b0 || epc !== 32'h8) begin
      tests_failed++;
      $display("FAIL int_pulse: we=%b epc=%h, want 0 00000008", epc_we, epc);
    end
    wait_req();
    tests_run++;
    if (imem_addr !== 32'h80) begin
      tests_failed++;
      $display("FAIL int_vector: addr=%h, want 00000080", imem_addr);
    end
    sb.push_back(mk(32'h80));
    sb.push_back(mk(32'h84));
    drain();
  endtask

  task automatic wait_req2();
    int b = 0;
    while (!req2 && b < 50) begin
      cycle();
      b++;
    end
    tests_run++;
    if (!req2) begin
      tests_failed++;
      $display("FAIL req2_timeout: req=%b, want 1", req2);
    end
  endtask

  task automatic test_wrap();
    int b = 0;
    rst2 = 1'b1;
    wait_req2();
    tests_run++;
    if (addr2 !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_first: addr=%h, want fffffffc", addr2);
    end
    while (!valid2 && b < 20) begin
      cycle();
      b++;
    end
    tests_run++;
    if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || inst2 !== fw(32'hFFFF_FFFC)) begin
      tests_failed++;
      $display("FAIL wrap_head: valid=%b pc=%h inst=%h, want 1 fffffffc %h", valid2, pc2, inst2, fw(32'hFFFF_FFFC));
    end
    wait_req2();
    tests_run++;
    if (addr2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_next: addr=%h, want 00000000", addr2);
    end
    ack2_en = 1'b0;
    cycle();
    wait_req2();
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    tests_run++;
    if (req2 !== 1'b0 || addr2 !== 32'h0 || valid2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: req=%b addr=%h valid=%b, want 0 0 0", req2, addr2, valid2);
    end
    @(posedge clk);
    #1;
    rst2    = 1'b1;
    ack2_en = 1'b1;
    wait_req2();
    tests_run++;
    if (addr2 !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL reset_refetch: addr=%h, want fffffffc", addr2);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_drop();
    test_jmpr_on_ack();
    test_interrupt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
